spi_regfile_burst: RTL and testbench
====================================

Name: spi_regfile_burst

Overview:
- Parametrised SPI mode-0 peripheral register file. It is the next-generation successor of the fixed 10-register SPI peripheral.
- Register count and data width are generic.
- Supports burst transfers with address auto-increment, true register read-back on CIPO, and per-frame write commit.
- Sits between the chip's SPI pins and the PWM and GPIO configuration logic. It drives a flat register bus plus a write strobe.

Parameters:
- NUM_REGS, 16: number of registers, 1..128.
- DATA_W, 8: register and data-frame width in bits, 1..32.
- SYNC_STAGES, 2: synchroniser depth on nCS, SCLK and COPI, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- nCS  in  1  SPI chip select, active low, asynchronous.
- SCLK  in  1  SPI clock, CPOL=0, asynchronous.
- COPI  in  1  controller-out data, asynchronous.
- CIPO  out  1  peripheral-out data, MSB first.
- CIPO_oe  out  1  high while nCS (synchronised) is low; the pad is tristated otherwise.
- reg_out  out  NUM_REGS*DATA_W  register contents; register i is at [i*DATA_W +: DATA_W].
- wr_stb  out  1  one-cycle pulse per committed write.
- wr_addr  out  7  address of the committed write.
- err  out  1  sticky flag; set by an out-of-range access or an aborted frame; cleared by a valid write to address 0x7F.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All flops update on the clk rising edge.
- Reset values: reg_out=0, CIPO=0, CIPO_oe=0, wr_stb=0, wr_addr=0, err=0, all state idle. Synchroniser flops reset to nCS=1, SCLK=0, COPI=0.
- Edge detection: rise and fall of SCLK, and rise of nCS, are taken from the last two synchroniser stages. SCLK must not exceed clk/8.
- Frame format: command byte, then any number of DATA_W-bit data frames. Bits are sampled on SCLK rising edges, MSB first.
- Command byte: bit7 = W (1 = write, 0 = read); bits6:0 = start address.
- State machine:
  - IDLE: go to CMD on nCS low.
  - CMD: count 8 bits, then go to DATA.
  - DATA: count DATA_W bits; at frame end, commit and stay in DATA.
  - Any state: nCS high returns to IDLE.
- Write commit: on the clk cycle after the SCLK rising edge that completes a data frame:
  - if the current address is below NUM_REGS, update that register and pulse wr_stb with wr_addr = address;
  - the address then increments.
- Address wrap: the address after NUM_REGS-1 is 0.
- Out-of-range handling: a start address of NUM_REGS or more sets err. All frames of that transaction are ignored for writes, and reads return 0. No wrap applies.
- Address 0x7F write: writes only clear err; there is no register and no wr_stb.
- Read path:
  - A DATA_W-bit shift register drives CIPO from its MSB.
  - It loads on the SCLK falling edge that follows the last bit of the command byte, or of each data frame. It loads from reg_out[address], or 0 if out of range.
  - It shifts left on all other SCLK falling edges.
  - The first read data bit is therefore valid before the first data-frame rising edge.
- Write transactions also drive read-back data: each frame returns the old value of the register it is about to write.
- Abort: nCS rising mid-command or mid-frame discards the partial frame, sets err if any bit of it was received, and commits nothing further. Frames already completed stay committed.
- Simultaneous events:
  - SCLK edge in the same cycle as nCS rise: nCS wins and the edge is ignored.
  - rst asserted mid-transaction: everything clears and the block stays in IDLE until nCS is seen high, then low again.

Decomposition:
- Shared package holds:
  - command bit positions (CMD_W_BIT=7, address field 6:0);
  - ERR_CLR_ADDR=7'h7F;
  - state enum IDLE/CMD/DATA.
- Natural sub-module: spi_sync_edge, a SYNC_STAGES synchroniser plus rise/fall detector, instantiated for SCLK and nCS, with a plain synchroniser for COPI.
- The main FSM, counters, register array and shift register remain in spi_regfile_burst.

Test Plan:
- Single write: cmd 0x83, data 0x5A → reg 3 = 0x5A; one wr_stb with wr_addr=3; other registers stay 0.
- Burst write wrap: cmd 0x8E, data 0x11 0x22 0x33 (NUM_REGS=16) → reg14=0x11, reg15=0x22, reg0=0x33; three wr_stb pulses.
- Burst read: preload reg5=0xA5 and reg6=0x3C; cmd 0x05 with 16 dummy clocks → CIPO returns 0xA5 then 0x3C; CIPO_oe is high only while nCS is low; no wr_stb.
- Abort: cmd 0x82, data 0xFF, then nCS high after 4 data bits → reg2 unchanged; err=1; a following write of 0x00 to 0x7F clears err.
- Out of range: cmd 0x90 (address 16), data 0x77 → no register changes; no wr_stb; err=1. A read of address 20 returns 0x00.
- Reset mid-burst: rst asserted during the second data frame → all registers 0, err 0; the next full transaction after an nCS high/low cycle works normally.

Source files
------------

// File: rtl/spi_regfile_burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_regfile_burst_pkg
//  Description : Shared command layout, special addresses and FSM encoding
//                for the SPI burst register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_regfile_burst_pkg;

    // Command byte layout: bit 7 selects write, bits 6:0 carry the start address
    localparam int CMD_W_BIT    = 7;
    localparam int CMD_ADDR_MSB = 6;
    localparam int CMD_ADDR_LSB = 0;
    localparam int CMD_BITS     = 8;

    // Writes to this address only clear the sticky error flag
    localparam logic [6:0] ERR_CLR_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_regfile_burst_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-stage synchroniser for an asynchronous pin with
//                rise/fall detection from the last two stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;

    // Shift the pin through the synchroniser chain; index 0 is the newest sample
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  =  sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];
    assign fall  = ~sync[SYNC_STAGES-2] &  sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_regfile_burst.sv
`default_nettype none
// ============================================================================
//  Module      : spi_regfile_burst
//  Description : SPI mode-0 peripheral register file with burst transfers,
//                address auto-increment, read-back on CIPO and per-frame
//                write commit onto a flat register bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_regfile_burst
    import spi_regfile_burst_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic                       wr_stb,
    output logic [6:0]                 wr_addr,
    output logic                       err
);

    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int         IN_W       = (DATA_W > CMD_BITS) ? DATA_W : CMD_BITS;
    localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);
    localparam logic [6:0] LAST_ADDR  = 7'(NUM_REGS - 1);
    localparam logic [5:0] CMD_LAST   = 6'(CMD_BITS - 1);
    localparam logic [5:0] DATA_LAST  = 6'(DATA_W - 1);

    // ---------------------------------------------------------------- inputs
    logic ncs_level, ncs_rise, ncs_fall;
    logic sclk_level_unused, sclk_rise_raw, sclk_fall_raw;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic                   copi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk      (clk),
        .rst      (rst),
        .async_in (nCS),
        .level    (ncs_level),
        .rise     (ncs_rise),
        .fall     (ncs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk      (clk),
        .rst      (rst),
        .async_in (SCLK),
        .level    (sclk_level_unused),
        .rise     (sclk_rise_raw),
        .fall     (sclk_fall_raw)
    );

    // Plain synchroniser for COPI; same depth keeps it aligned with SCLK
    always_ff @(posedge clk) begin
        if (rst) begin
            copi_sync <= '0;
        end else begin
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
        end
    end

    assign copi_s = copi_sync[SYNC_STAGES-1];

    // ----------------------------------------------------------------- state
    state_t                state, state_next;
    logic [SYNC_STAGES-1:0] prime;
    logic                  armed;
    logic [5:0]            bit_cnt;
    logic [IN_W-2:0]       shift_in;
    logic [IN_W-1:0]       shift_next;
    logic [6:0]            addr, next_addr;
    logic                  is_write, oor, is_clr, addr_ok;
    logic                  sclk_rise, sclk_fall;
    logic                  cmd_done, frame_done, do_write, do_clr, start_oor, abort;
    logic [7:0]            cmd_word;
    logic [DATA_W-1:0]     data_word, rd_word, rd_shift;
    logic [DATA_W-1:0]     regs [NUM_REGS];

    // An nCS rise in the same cycle as an SCLK edge wins; the edge is dropped
    assign sclk_rise  = sclk_rise_raw & ~ncs_rise & (state != IDLE);
    assign sclk_fall  = sclk_fall_raw & ~ncs_rise & (state != IDLE);
    assign shift_next = {shift_in, copi_s};
    assign cmd_word   = shift_next[7:0];
    assign data_word  = shift_next[DATA_W-1:0];
    assign cmd_done   = sclk_rise & (state == CMD)  & (bit_cnt == CMD_LAST);
    assign frame_done = sclk_rise & (state == DATA) & (bit_cnt == DATA_LAST);

    // The clear address is never a real register, even when NUM_REGS is 128
    assign is_clr     = (addr == ERR_CLR_ADDR);
    assign addr_ok    = ~oor & ~is_clr;
    assign do_write   = frame_done & is_write & addr_ok;
    assign do_clr     = frame_done & is_write & is_clr;
    assign start_oor  = ({1'b0, cmd_word[CMD_ADDR_MSB:CMD_ADDR_LSB]} >= NUM_REGS_L) &
                        (cmd_word[CMD_ADDR_MSB:CMD_ADDR_LSB] != ERR_CLR_ADDR);
    assign abort      = ncs_rise & (state != IDLE) & (bit_cnt != 6'd0);
    assign next_addr  = (addr == LAST_ADDR) ? 7'd0 : addr + 7'd1;
    assign rd_word    = addr_ok ? regs[addr[AW-1:0]] : '0;

    // Arm only once the synchroniser holds real samples and nCS reads high,
    // so a reset in the middle of a frame cannot start a bogus transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            prime <= '0;
            armed <= 1'b0;
        end else begin
            prime <= {prime[SYNC_STAGES-2:0], 1'b1};
            if (prime[SYNC_STAGES-1] && ncs_level) begin
                armed <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: command byte first, then data frames until nCS rises
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (armed && ncs_fall) state_next = CMD;
            CMD: begin
                if (ncs_rise)      state_next = IDLE;
                else if (cmd_done) state_next = DATA;
            end
            DATA: if (ncs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame datapath: bit counting, command decode, address stepping, error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            shift_in <= '0;
            addr     <= '0;
            is_write <= 1'b0;
            oor      <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            err      <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_in <= shift_next[IN_W-2:0];
                bit_cnt  <= (cmd_done || frame_done) ? 6'd0 : bit_cnt + 6'd1;
            end
            if (cmd_done) begin
                addr     <= cmd_word[CMD_ADDR_MSB:CMD_ADDR_LSB];
                is_write <= cmd_word[CMD_W_BIT];
                oor      <= start_oor;
            end
            // Out-of-range and clear-address transactions keep their address
            if (frame_done && addr_ok) begin
                addr <= next_addr;
            end
            if (do_write) begin
                wr_stb  <= 1'b1;
                wr_addr <= addr;
            end
            if (do_clr) begin
                err <= 1'b0;
            end
            if ((cmd_done && start_oor) || abort) begin
                err <= 1'b1;
            end
        end
    end

    // Register array, written once per completed in-range write frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            regs[addr[AW-1:0]] <= data_word;
        end
    end

    // Read-back shifter: load at the first falling edge of each data frame,
    // which precedes that frame's commit, so writes return the old value
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            rd_shift <= '0;
        end else if (sclk_fall) begin
            if (state == DATA && bit_cnt == 6'd0) begin
                rd_shift <= rd_word;
            end else begin
                rd_shift <= rd_shift << 1;
            end
        end
    end

    assign CIPO    = rd_shift[DATA_W-1];
    assign CIPO_oe = ~ncs_level;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign reg_out[gi*DATA_W +: DATA_W] = regs[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_regfile_burst
//  Description : Directed scoreboard bench for spi_regfile_burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_regfile_burst;

    localparam int NUM_REGS    = 16;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int RW          = NUM_REGS * DATA_W;
    localparam int HALF        = 8;   // clk cycles per SCLK half period

    logic          clk = 1'b0;
    logic          rst, nCS, SCLK, COPI;
    logic          CIPO, CIPO_oe, wr_stb, err;
    logic [RW-1:0] reg_out;
    logic [6:0]    wr_addr;

    spi_regfile_burst #(
        .NUM_REGS    (NUM_REGS),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .nCS     (nCS),
        .SCLK    (SCLK),
        .COPI    (COPI),
        .CIPO    (CIPO),
        .CIPO_oe (CIPO_oe),
        .reg_out (reg_out),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t           wr_q[$];
    logic [7:0]    rd_q[$];
    logic [RW-1:0] exp_vec;
    logic [7:0]    rx_byte;
    logic          rx_valid = 1'b0;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each write strobe and each returned data frame
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr_stb: wr_addr=%0d none expected", wr_addr);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", RW'(wr_addr), RW'(e.a));
                check("wr_data", RW'(reg_out[e.a*DATA_W +: DATA_W]), RW'(e.d));
            end
        end
        if (rx_valid) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rx: got %0h none expected", rx_byte);
            end else begin
                logic [7:0] e;
                e = rd_q.pop_front();
                check("cipo_byte", RW'(rx_byte), RW'(e));
            end
        end
    end

    task automatic sclk_cycle(input logic b_out, output logic b_in);
        COPI = b_out;
        repeat (HALF) @(posedge clk);
        b_in = CIPO;
        SCLK = 1'b1;
        repeat (HALF) @(posedge clk);
        SCLK = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int nbits, input bit report);
        logic [7:0] rx;
        logic       b;
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            sclk_cycle(v[i], b);
            rx = {rx[6:0], b};
        end
        if (report) begin
            rx_byte  = rx;
            rx_valid = 1'b1;
            @(posedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic begin_cs();
        nCS = 1'b0;
        repeat (HALF) @(posedge clk);
        @(negedge clk);
        check("cipo_oe_active", RW'(CIPO_oe), RW'(1'b1));
    endtask

    task automatic end_cs();
        repeat (HALF) @(posedge clk);
        nCS = 1'b1;
        repeat (4 * HALF) @(posedge clk);
    endtask

    task automatic xfer(input logic [7:0] cmd, input int n, input logic [7:0] d0,
                        input logic [7:0] d1, input logic [7:0] d2, input bit report);
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        begin_cs();
        send_byte(cmd, 8, 1'b0);
        for (int k = 0; k < n; k++) send_byte(d[k], 8, report);
        end_cs();
    endtask

    task automatic set_reg(input int a, input logic [7:0] d);
        exp_vec[a*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        rst = 1'b1; nCS = 1'b1; SCLK = 1'b0; COPI = 1'b0;
        exp_vec = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_reg_out", reg_out, '0);
        check("rst_wr_stb",  RW'(wr_stb), '0);
        check("rst_wr_addr", RW'(wr_addr), '0);
        check("rst_err",     RW'(err), '0);
        check("rst_cipo",    RW'(CIPO), '0);
        check("rst_cipo_oe", RW'(CIPO_oe), '0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Single write
        rd_q.push_back(8'h00);
        wr_q.push_back({7'd3, 8'h5A});
        set_reg(3, 8'h5A);
        xfer(8'h83, 1, 8'h5A, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        check("single_regs", reg_out, exp_vec);
        check("single_err", RW'(err), '0);
        check("cipo_oe_idle", RW'(CIPO_oe), '0);

        // Burst write wrapping 14 -> 15 -> 0
        rd_q.push_back(8'h00); rd_q.push_back(8'h00); rd_q.push_back(8'h00);
        wr_q.push_back({7'd14, 8'h11});
        wr_q.push_back({7'd15, 8'h22});
        wr_q.push_back({7'd0,  8'h33});
        set_reg(14, 8'h11); set_reg(15, 8'h22); set_reg(0, 8'h33);
        xfer(8'h8E, 3, 8'h11, 8'h22, 8'h33, 1'b1);
        @(negedge clk);
        check("wrap_regs", reg_out, exp_vec);

        // Preload 5/6, then burst read them back
        rd_q.push_back(8'h00); rd_q.push_back(8'h00);
        wr_q.push_back({7'd5, 8'hA5});
        wr_q.push_back({7'd6, 8'h3C});
        set_reg(5, 8'hA5); set_reg(6, 8'h3C);
        xfer(8'h85, 2, 8'hA5, 8'h3C, 8'h00, 1'b1);
        rd_q.push_back(8'hA5); rd_q.push_back(8'h3C);
        xfer(8'h05, 2, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        check("read_regs", reg_out, exp_vec);
        check("read_err", RW'(err), '0);
        check("read_cipo_oe_idle", RW'(CIPO_oe), '0);

        // Abort after 4 data bits, then clear err via 0x7F
        begin_cs();
        send_byte(8'h82, 8, 1'b0);
        send_byte(8'hFF, 4, 1'b0);
        end_cs();
        @(negedge clk);
        check("abort_regs", reg_out, exp_vec);
        check("abort_err", RW'(err), RW'(1'b1));
        xfer(8'hFF, 1, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        check("clr_err", RW'(err), '0);
        check("clr_regs", reg_out, exp_vec);

        // Out-of-range write, then out-of-range read
        rd_q.push_back(8'h00);
        xfer(8'h90, 1, 8'h77, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        check("oor_regs", reg_out, exp_vec);
        check("oor_err", RW'(err), RW'(1'b1));
        rd_q.push_back(8'h00);
        xfer(8'h14, 1, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        check("oor_read_err", RW'(err), RW'(1'b1));
        xfer(8'hFF, 1, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        check("oor_clr_err", RW'(err), '0);

        // Reset during the second data frame of a burst
        rd_q.push_back(8'h00);
        wr_q.push_back({7'd1, 8'h99});
        begin_cs();
        send_byte(8'h81, 8, 1'b0);
        send_byte(8'h99, 8, 1'b1);
        send_byte(8'h66, 3, 1'b0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        rst = 1'b0;
        exp_vec = '0;
        @(negedge clk);
        check("midrst_regs", reg_out, exp_vec);
        check("midrst_err", RW'(err), '0);
        send_byte(8'h00, 5, 1'b0);
        end_cs();
        @(negedge clk);
        check("midrst_regs_after", reg_out, exp_vec);
        check("midrst_err_after", RW'(err), '0);
        rd_q.push_back(8'h00);
        wr_q.push_back({7'd4, 8'hC3});
        set_reg(4, 8'hC3);
        xfer(8'h84, 1, 8'hC3, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        check("post_rst_regs", reg_out, exp_vec);
        check("post_rst_err", RW'(err), '0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("wr_q_drained", RW'(wr_q.size()), '0);
        check("rd_q_drained", RW'(rd_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
